// File: rtl/apb4_param_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : apb4_param_reg_bank
// Description : APB4 slave with NUM_REGS 32-bit data registers, a CTRL word
//               holding a sticky LOCK bit, a read-only CoreSight-style ID
//               block and a configurable number of access-phase wait states.
// Ports       : pclk, presetn (async, active-low)
//               psel, penable, pwrite, paddr, pstrb, pprot, pwdata (APB4 in)
//               ecorevnum (ECO revision, reported in PID3)
//               prdata, pready, pslverr (APB4 out)
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_param_reg_bank #(
    parameter int ADDRWIDTH   = 12,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic [3:0]           pstrb,
    input  logic [2:0]           pprot,
    input  logic [31:0]          pwdata,
    input  logic [3:0]           ecorevnum,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr
);

    localparam int         c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_wait_cnt;
    logic [3:0]    w_wait_nxt;
    logic [31:0]   r_regs [NUM_REGS];
    logic          r_lock;

    logic [11:0]        w_off;
    logic [9:0]         w_word;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_hi_ok;
    logic               w_hit_data;
    logic               w_hit_ctrl;
    logic               w_hit_id;
    logic               w_mapped;
    logic               w_wr_err;
    logic               w_err;
    logic               w_complete;
    logic               w_commit;
    logic [31:0]        w_id_data;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Address decode. Everything above the 4 KB window is unmapped.
    // ------------------------------------------------------------------
    assign w_off      = paddr[11:0];
    assign w_word     = w_off[11:2];
    assign w_idx      = w_off[c_IDX_W+1:2];
    assign w_hi_ok    = ((paddr >> 12) == '0);
    assign w_hit_data = w_hi_ok && (w_off < 12'h800) && (w_word < 10'(NUM_REGS));
    assign w_hit_ctrl = w_hi_ok && (w_word == 10'h200);
    // 0xFC0-0xFFC: reserved words read 0, ID words read constants
    assign w_hit_id   = w_hi_ok && (w_off >= 12'hFC0);
    assign w_mapped   = w_hit_data || w_hit_ctrl || w_hit_id;

    // Reads ignore pprot and LOCK; writes need privilege and a writable target
    assign w_wr_err = !pprot[0] || !w_mapped || w_hit_id || (w_hit_data && r_lock);
    assign w_err    = pwrite ? w_wr_err : !w_mapped;

    assign w_complete = (r_state == ST_ACCESS) && psel && penable && (r_wait_cnt == 4'd0);
    assign w_commit   = w_complete && pwrite && !w_wr_err;

    assign w_unused = ^{pprot[2:1], paddr[1:0]};

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt = ST_ACCESS;
                    w_wait_nxt  = c_WAIT;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    // master abandoned the transfer: drop it without a commit
                    w_state_nxt = ST_IDLE;
                    w_wait_nxt  = 4'd0;
                end else if (r_wait_cnt != 4'd0) begin
                    w_wait_nxt = r_wait_cnt - 4'd1;
                end else if (penable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wait_nxt  = 4'd0;
            end
        endcase
    end

    assign pready = (r_state == ST_IDLE) || (r_wait_cnt == 4'd0);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_commit && w_hit_data) begin
            for (int b = 0; b < 4; b++) begin
                if (pstrb[b]) begin
                    r_regs[w_idx][8*b +: 8] <= pwdata[8*b +: 8];
                end
            end
        end
    end

    // LOCK is sticky: only a reset clears it
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_lock <= 1'b0;
        end else if (w_commit && w_hit_ctrl && pstrb[0] && pwdata[0]) begin
            r_lock <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_id_data = 32'd0;
        case (w_off[5:2])
            4'h4:    w_id_data = 32'h0000_0004;
            4'h8:    w_id_data = 32'h0000_0019;
            4'h9:    w_id_data = 32'h0000_00B8;
            4'hA:    w_id_data = 32'h0000_001B;
            4'hB:    w_id_data = {24'h0, ecorevnum, 4'h0};
            4'hC:    w_id_data = 32'h0000_000D;
            4'hD:    w_id_data = 32'h0000_00F0;
            4'hE:    w_id_data = 32'h0000_0005;
            4'hF:    w_id_data = 32'h0000_00B1;
            default: w_id_data = 32'd0;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit_data) begin
            w_rdata = r_regs[w_idx];
        end else if (w_hit_ctrl) begin
            w_rdata = {31'd0, r_lock};
        end else if (w_hit_id) begin
            w_rdata = w_id_data;
        end
    end

    assign prdata  = (w_complete && !pwrite) ? w_rdata : 32'd0;
    assign pslverr = w_complete ? w_err : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_apb4_param_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb4_param_reg_bank
// Description : Self-checking bench for apb4_param_reg_bank. Two instances
//               (0 and 3 wait states) on separate buses share clock/reset.
//               A transfer-level register model predicts prdata/pready/
//               pslverr every cycle; directed vectors add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_param_reg_bank;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic [3:0]  ecorevnum = 4'hA;

    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [11:0] paddr   [2];
    logic [3:0]  pstrb   [2];
    logic [2:0]  pprot   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    // model state
    logic [31:0] mem  [2][8];
    logic        lock [2];
    int          ph   [2];   // 0: idle/setup, k>0: k-th access cycle, -1: aborting

    int vectors = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    apb4_param_reg_bank #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn),
        .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pstrb(pstrb[0]), .pprot(pprot[0]), .pwdata(pwdata[0]),
        .ecorevnum(ecorevnum),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    apb4_param_reg_bank #(.ADDRWIDTH(12), .NUM_REGS(8), .WAIT_STATES(3)) u_dut1 (
        .pclk(pclk), .presetn(presetn),
        .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pstrb(pstrb[1]), .pprot(pprot[1]), .pwdata(pwdata[1]),
        .ecorevnum(ecorevnum),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Register model (address-map level)
    // ---------------------------------------------------------------
    function automatic logic m_mapped(input logic [11:0] a);
        return (a < 12'h800 && a[11:2] < 10'd8) || (a[11:2] == 10'h200) || (a >= 12'hFC0);
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [11:0] addr);
        logic [11:0] a;
        a = addr & 12'hFFC;
        if (a < 12'h800) return (a[11:2] < 10'd8) ? mem[d][a[4:2]] : 32'd0;
        if (a == 12'h800) return {31'd0, lock[d]};
        case (a)
            12'hFD0: return 32'h04;
            12'hFE0: return 32'h19;
            12'hFE4: return 32'hB8;
            12'hFE8: return 32'h1B;
            12'hFEC: return {24'h0, ecorevnum, 4'h0};
            12'hFF0: return 32'h0D;
            12'hFF4: return 32'hF0;
            12'hFF8: return 32'h05;
            12'hFFC: return 32'hB1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_err(input int d);
        logic [11:0] a;
        a = paddr[d] & 12'hFFC;
        if (!m_mapped(a)) return 1'b1;
        if (!pwrite[d])   return 1'b0;
        if (!pprot[d][0]) return 1'b1;
        if (a >= 12'hFC0) return 1'b1;
        if (a < 12'h800 && lock[d]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_write(input int d);
        logic [11:0] a;
        a = paddr[d] & 12'hFFC;
        if (a < 12'h800) begin
            for (int b = 0; b < 4; b++)
                if (pstrb[d][b]) mem[d][a[4:2]][8*b +: 8] = pwdata[d][8*b +: 8];
        end else if (a == 12'h800 && pstrb[d][0] && pwdata[d][0]) begin
            lock[d] = 1'b1;
        end
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            lock[d] = 1'b0;
            for (int i = 0; i < 8; i++) mem[d][i] = 32'd0;
        end
    endtask

    // ---------------------------------------------------------------
    // Per-cycle compare against the model
    // ---------------------------------------------------------------
    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            logic        ep;
            logic [31:0] ed;
            logic        ee;
            ep = 1'b1; ed = 32'd0; ee = 1'b0;
            if (ph[d] > 0) begin
                ep = (ph[d] > ws(d));
                if (ep) begin
                    ed = pwrite[d] ? 32'd0 : m_read(d, paddr[d]);
                    ee = m_err(d);
                end
            end
            if (ph[d] >= 0) chk($sformatf("cyc%0d.pready", d), {31'd0, pready[d]}, {31'd0, ep});
            chk($sformatf("cyc%0d.prdata", d), prdata[d], ed);
            chk($sformatf("cyc%0d.pslverr", d), {31'd0, pslverr[d]}, {31'd0, ee});
        end
    end

    // ---------------------------------------------------------------
    // Bus driver
    // ---------------------------------------------------------------
    task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                        output logic [31:0] rd, output logic er, output int waits);
        logic done;
        logic e_model;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
        pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr; ph[d] = 0;
        @(posedge pclk); #1;
        penable[d] = 1'b1; ph[d] = 1;
        waits = 0; done = 1'b0; rd = 32'd0; er = 1'b0; e_model = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk);
            if (pready[d] === 1'b1) begin
                done = 1'b1; rd = prdata[d]; er = pslverr[d]; e_model = m_err(d);
            end else begin
                waits++;
            end
            @(posedge pclk); #1;
            if (!done) ph[d] = ph[d] + 1;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL timeout: pready never rose on bus %0d addr %03h", d, a);
        end else if (wr && !e_model) begin
            m_write(d);
        end
        psel[d] = 1'b0; penable[d] = 1'b0; ph[d] = 0;
    endtask

    task automatic wr_chk(input int d, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input logic exp_err,
                          input string name);
        logic [31:0] rd; logic er; int w;
        xfer(d, 1'b1, a, wd, st, pr, rd, er, w);
        chk({name, ".pslverr"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input int d, input logic [11:0] a, input logic [31:0] exp_d,
                          input logic exp_err, input string name);
        logic [31:0] rd; logic er; int w;
        xfer(d, 1'b0, a, 32'd0, 4'h0, 3'b000, rd, er, w);
        chk({name, ".prdata"}, rd, exp_d);
        chk({name, ".pslverr"}, {31'd0, er}, {31'd0, exp_err});
        chk({name, ".waits"}, w, ws(d));
    endtask

    // ---------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0;
            pstrb[d] = '0; pprot[d] = '0; pwdata[d] = '0; ph[d] = 0;
        end
        m_reset();
        #1 presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset.pready0", {31'd0, pready[0]}, 32'd1);
        chk("reset.prdata1", prdata[1], 32'd0);
        presetn = 1'b1;
        @(posedge pclk); #1;

        // basic write/read, zero wait states
        wr_chk(0, 12'h004, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0, "wr004");
        rd_chk(0, 12'h004, 32'hDEADBEEF, 1'b0, "rd004");

        // byte strobes
        wr_chk(0, 12'h000, 32'h11223344, 4'hF, 3'b001, 1'b0, "wr000");
        wr_chk(0, 12'h000, 32'hAABBCCDD, 4'h5, 3'b001, 1'b0, "wr000s5");
        rd_chk(0, 12'h000, 32'h11BB33DD, 1'b0, "rd000s5");

        // ID block through the three-wait-state instance
        rd_chk(1, 12'hFE0, 32'h19, 1'b0, "pid0");
        rd_chk(1, 12'hFEC, 32'hA0, 1'b0, "pid3");
        rd_chk(1, 12'hFF0, 32'h0D, 1'b0, "cid0");
        rd_chk(1, 12'hFD0, 32'h04, 1'b0, "pid4");
        rd_chk(1, 12'hFC0, 32'h00, 1'b0, "resv");

        // errors: unmapped, unprivileged, ID write, empty strobe
        rd_chk(0, 12'h020, 32'd0, 1'b1, "unmapped020");
        rd_chk(0, 12'h900, 32'd0, 1'b1, "unmapped900");
        wr_chk(0, 12'h008, 32'h12345678, 4'hF, 3'b000, 1'b1, "wrunpriv");
        rd_chk(0, 12'h008, 32'd0, 1'b0, "rd008");
        wr_chk(0, 12'hFD0, 32'hFFFFFFFF, 4'hF, 3'b001, 1'b1, "wrid");
        wr_chk(0, 12'h00C, 32'hCAFEF00D, 4'h0, 3'b001, 1'b0, "wrnostrb");
        rd_chk(0, 12'h00C, 32'd0, 1'b0, "rd00C");

        // LOCK behaviour
        wr_chk(0, 12'h800, 32'h1, 4'hF, 3'b001, 1'b0, "lockset");
        wr_chk(0, 12'h000, 32'h55, 4'hF, 3'b001, 1'b1, "wrlocked");
        rd_chk(0, 12'h000, 32'h11BB33DD, 1'b0, "rdlocked");
        rd_chk(0, 12'h800, 32'h1, 1'b0, "ctrl1");
        wr_chk(0, 12'h800, 32'h0, 4'hF, 3'b001, 1'b0, "lockclr");
        rd_chk(0, 12'h800, 32'h1, 1'b0, "ctrlsticky");

        // waited write + read-back
        wr_chk(1, 12'h010, 32'h0BADF00D, 4'hF, 3'b011, 1'b0, "wr010ws");
        rd_chk(1, 12'h010, 32'h0BADF00D, 1'b0, "rd010ws");

        // psel dropped mid-access: no commit
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h00C;
        pwdata[1] = 32'h77777777; pstrb[1] = 4'hF; pprot[1] = 3'b001;
        @(posedge pclk); #1; penable[1] = 1'b1; ph[1] = 1;
        @(posedge pclk); #1; psel[1] = 1'b0; penable[1] = 1'b0; ph[1] = -1;
        @(posedge pclk); #1; ph[1] = 0;
        rd_chk(1, 12'h00C, 32'd0, 1'b0, "abort");

        // reset asserted during the access phase of a write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h008;
        pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF; pprot[1] = 3'b001;
        @(posedge pclk); #1; penable[1] = 1'b1; ph[1] = 1;
        #2;
        presetn = 1'b0; ph[1] = 0; psel[1] = 1'b0; penable[1] = 1'b0;
        m_reset();
        #1;
        chk("midrst.pready", {31'd0, pready[1]}, 32'd1);
        chk("midrst.prdata", prdata[1], 32'd0);
        chk("midrst.pslverr", {31'd0, pslverr[1]}, 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        rd_chk(1, 12'h008, 32'd0, 1'b0, "postrst.reg2");
        rd_chk(1, 12'h010, 32'd0, 1'b0, "postrst.reg4");
        rd_chk(0, 12'h800, 32'd0, 1'b0, "postrst.lock");
        rd_chk(0, 12'h004, 32'd0, 1'b0, "postrst.reg1");
        wr_chk(0, 12'h000, 32'h55, 4'hF, 3'b001, 1'b0, "postrst.wr");
        rd_chk(0, 12'h000, 32'h55, 1'b0, "postrst.rd");

        repeat (2) @(posedge pclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/apb4_param_reg_bank.md
APB4_PARAM_REG_BANK -- requirements
Module: apb4_param_reg_bank

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 12, APB address width (minimum 12).
REQ-002 SHALL have parameter NUM_REGS, default 8, count of 32-bit data registers (range 1..64).
REQ-003 SHALL have parameter WAIT_STATES, default 0, access-phase wait cycles per transfer (range 0..15).
REQ-004 SHALL have pclk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have presetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have psel, penable, pwrite  input  1 each  APB4 select, enable, direction (1 = write).
REQ-007 SHALL have paddr  input  ADDRWIDTH  byte address; bits [1:0] ignored.
REQ-008 SHALL have pstrb  input  4  write byte strobes; pstrb[n] enables pwdata[8n+7:8n].
REQ-009 SHALL have pprot  input  3  protection; only pprot[0] (1 = privileged) is used.
REQ-010 SHALL have pwdata  input  32  write data.
REQ-011 SHALL have ecorevnum  input  4  ECO revision, quasi-static.
REQ-012 SHALL have prdata  output  32  read data, valid when pready=1.
REQ-013 SHALL have pready  output  1  transfer complete.
REQ-014 SHALL have pslverr  output  1  transfer error, valid when pready=1.

Function
REQ-015 SHALL map data register i (0..NUM_REGS-1) at byte offset 4*i; all other offsets below 0x800 are unmapped.
REQ-016 SHALL implement CTRL at offset 0x800: bit0 LOCK, sticky-set (write 1 sets, write 0 has no effect), other bits read 0.
REQ-017 SHALL implement read-only ID words at 0xFD0-0xFFC: PID4=0x04, PID5-7=0x00, PID0=0x19, PID1=0xB8, PID2=0x1B, PID3={24'h0, ecorevnum, 4'h0}, CID0-3=0x0D, 0xF0, 0x05, 0xB1; 0xFC0-0xFCC read 0.
REQ-018 SHALL implement a two-state FSM: IDLE, ACCESS.
REQ-019 SHALL, in IDLE with psel=1 and penable=0 (setup), load wait counter with WAIT_STATES and move to ACCESS.
REQ-020 SHALL, in ACCESS, drive pready=1 iff counter==0; when counter!=0, decrement by 1 per cycle.
REQ-021 SHALL return to IDLE after the ACCESS cycle with pready=1, psel=1 and penable=1 (completion cycle).
REQ-022 SHALL drive pready=1 whenever the FSM is in IDLE.
REQ-023 SHALL, with WAIT_STATES=N, complete every transfer in exactly N+2 cycles including setup.
REQ-024 SHALL commit a write only on the completion cycle, updating only bytes with pstrb set; pstrb=0 writes nothing and gives no error.
REQ-025 SHALL assert pslverr on the completion cycle for: unprivileged write (pprot[0]=0), data-register write while LOCK=1, any write to the ID region, or any access to an unmapped offset; an erroring write changes no state.
REQ-026 SHALL perform reads regardless of pprot and LOCK; unmapped reads return prdata=0 with pslverr=1.
REQ-027 SHALL drive prdata=0 and pslverr=0 on every cycle other than a read completion cycle (pslverr also on write completion).
REQ-028 SHALL, if psel drops while in ACCESS (protocol violation), return to IDLE without committing a write.
REQ-029 SHALL sample paddr, pwrite, pwdata, pstrb and pprot on the completion cycle; they are required stable through ACCESS.

Reset
REQ-030 SHALL, on presetn=0, asynchronously clear all data registers, LOCK, and the wait counter, and force the FSM to IDLE.
REQ-031 SHALL hold prdata=0, pready=1, pslverr=0 during reset.
REQ-032 SHALL abort any in-flight transfer when reset asserts mid-ACCESS; no partial write is retained.

Verification
REQ-033 SHALL test: WAIT_STATES=0, privileged write 0xDEADBEEF pstrb=0xF to 0x004, then read 0x004 -> prdata=0xDEADBEEF, pready high in access cycle, pslverr=0.
REQ-034 SHALL test: reg0=0x11223344, write 0xAABBCCDD pstrb=0x5 -> read returns 0x11BB33DD.
REQ-035 SHALL test: WAIT_STATES=3, read 0xFE0 -> pready low 3 access cycles, then high with prdata=0x19; total transfer 5 cycles.
REQ-036 SHALL test: write 0x1 to 0x800, then write 0x55 to 0x000 -> pslverr=1, reg0 unchanged, CTRL reads 0x1; write 0x0 to 0x800 leaves LOCK=1.
REQ-037 SHALL test: NUM_REGS=8, read 0x020 -> prdata=0, pslverr=1; write with pprot=0 -> pslverr=1, no update.
REQ-038 SHALL test: presetn pulsed low during ACCESS of write 0xFFFFFFFF to 0x008 -> reg2 reads 0, LOCK=0, pready=1 after reset.
